// File: rtl/boot_ram.sv
// ============================================================================
//  Module   : boot_ram
//  Function : Single-port word RAM with byte enables that clears itself after
//             reset (or on request) and optionally loads a boot image.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module boot_ram #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 7,
    parameter int MEM_KIND  = 0,
    parameter int BOOT_BASE = 0,
    parameter int BOOT_LEN  = 4,
    parameter logic [BOOT_LEN*DATA_W-1:0] BOOT_IMG = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clr_req,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy
);

    localparam int c_depth  = 2 ** ADDR_W;
    localparam int c_nbytes = DATA_W / 8;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(c_depth - 1);
    localparam logic [ADDR_W-1:0] c_boot_last = ADDR_W'(BOOT_LEN - 1);
    localparam logic [ADDR_W-1:0] c_boot_base = ADDR_W'(BOOT_BASE);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_BOOT  = 2'd1;
    localparam logic [1:0] S_IDLE  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;

    logic [DATA_W-1:0]   r_mem [c_depth];

    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [c_nbytes-1:0] w_mem_be;
    logic                w_rd_acc;
    logic [31:0]         w_boot_lsb;
    logic [DATA_W-1:0]   w_boot_word;

    assign w_boot_lsb  = 32'(r_cnt) * 32'(DATA_W);
    assign w_boot_word = BOOT_IMG[w_boot_lsb +: DATA_W];

    // The same counter walks the clear addresses and then the boot word index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == c_last_addr) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (MEM_KIND == 1) ? S_BOOT : S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BOOT: begin
                if (r_cnt == c_boot_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (clr_req) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CLEAR;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    always_comb begin
        busy        = 1'b1;
        req_ready   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_cnt;
        w_mem_wdata = '0;
        w_mem_be    = '1;
        case (r_state)
            S_CLEAR: begin
                w_mem_we = 1'b1;
            end
            S_BOOT: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = c_boot_base + r_cnt;
                w_mem_wdata = w_boot_word;
            end
            S_IDLE: begin
                busy        = 1'b0;
                req_ready   = !clr_req;
                w_mem_we    = req_valid && !clr_req && req_we;
                w_mem_addr  = req_addr;
                w_mem_wdata = req_wdata;
                w_mem_be    = req_be;
            end
            default: ;
        endcase
    end

    assign w_rd_acc = req_ready && req_valid && !req_we;

    // Memory contents are deliberately not reset; the init sequence defines them.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_nbytes; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_addr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= w_rd_acc;
            if (w_rd_acc) begin
                rsp_rdata <= r_mem[req_addr];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_boot_ram.sv
// ============================================================================
//  Module   : tb_boot_ram
//  Function : Directed, table-driven self-checking bench for boot_ram.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_boot_ram;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: 32-bit instruction memory with a two-word boot image at 3.
    logic        a_reset = 1'b1;
    logic        a_clr_req = 1'b0;
    logic        a_req_valid = 1'b0;
    logic        a_req_ready;
    logic        a_req_we = 1'b0;
    logic [3:0]  a_req_be = 4'h0;
    logic [6:0]  a_req_addr = 7'd0;
    logic [31:0] a_req_wdata = 32'd0;
    logic        a_rsp_valid;
    logic [31:0] a_rsp_rdata;
    logic        a_busy;

    boot_ram #(
        .DATA_W   (32),
        .ADDR_W   (7),
        .MEM_KIND (1),
        .BOOT_BASE(3),
        .BOOT_LEN (2),
        .BOOT_IMG ({32'h20A50005, 32'h0800000F})
    ) u_dut_a (
        .clock    (clock),
        .reset    (a_reset),
        .clr_req  (a_clr_req),
        .req_valid(a_req_valid),
        .req_ready(a_req_ready),
        .req_we   (a_req_we),
        .req_be   (a_req_be),
        .req_addr (a_req_addr),
        .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rsp_rdata),
        .busy     (a_busy)
    );

    // Instance B: 16-bit data memory, 16 words.
    logic        b_reset = 1'b1;
    logic        b_clr_req = 1'b0;
    logic        b_req_valid = 1'b0;
    logic        b_req_ready;
    logic        b_req_we = 1'b0;
    logic [1:0]  b_req_be = 2'b00;
    logic [3:0]  b_req_addr = 4'd0;
    logic [15:0] b_req_wdata = 16'd0;
    logic        b_rsp_valid;
    logic [15:0] b_rsp_rdata;
    logic        b_busy;

    boot_ram #(
        .DATA_W  (16),
        .ADDR_W  (4),
        .MEM_KIND(0)
    ) u_dut_b (
        .clock    (clock),
        .reset    (b_reset),
        .clr_req  (b_clr_req),
        .req_valid(b_req_valid),
        .req_ready(b_req_ready),
        .req_we   (b_req_we),
        .req_be   (b_req_be),
        .req_addr (b_req_addr),
        .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata),
        .busy     (b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts rising edges until instance A leaves init, bounded.
    task automatic a_wait_idle(output int n);
        n = 0;
        while (a_busy && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic a_req(input logic we, input logic [3:0] be, input logic [6:0] addr,
                         input logic [31:0] wdata);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_be    = be;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        tick();
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic        exp_valid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;

        vecs[0] = '{1'b0, 4'h0, 7'd3,   32'h0,        1'b1, 32'h0800000F};
        vecs[1] = '{1'b0, 4'h0, 7'd4,   32'h0,        1'b1, 32'h20A50005};
        vecs[2] = '{1'b0, 4'h0, 7'd5,   32'h0,        1'b1, 32'h00000000};
        vecs[3] = '{1'b0, 4'h0, 7'd2,   32'h0,        1'b1, 32'h00000000};
        vecs[4] = '{1'b1, 4'hF, 7'd10,  32'hAABBCCDD, 1'b0, 32'h00000000};
        vecs[5] = '{1'b1, 4'h5, 7'd10,  32'h11223344, 1'b0, 32'h00000000};
        vecs[6] = '{1'b0, 4'h0, 7'd10,  32'h0,        1'b1, 32'hAA22CC44};
        vecs[7] = '{1'b1, 4'hF, 7'd127, 32'hDEADBEEF, 1'b0, 32'hAA22CC44};
        vecs[8] = '{1'b0, 4'h0, 7'd127, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[9] = '{1'b0, 4'h0, 7'd0,   32'h0,        1'b1, 32'h00000000};

        // Reset state.
        tick();
        tick();
        chk("reset busy", 32'(a_busy), 32'd1);
        chk("reset ready", 32'(a_req_ready), 32'd0);
        chk("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("reset rsp_rdata", a_rsp_rdata, 32'd0);

        // Init length after reset release.
        a_reset = 1'b0;
        a_wait_idle(n);
        chk("init cycles", 32'(n), 32'd130);
        chk("idle ready", 32'(a_req_ready), 32'd1);

        // Back-to-back table: reads, byte-enable writes, write-then-read.
        for (int i = 0; i < 10; i++) begin
            a_req(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d rsp_valid", i), 32'(a_rsp_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d rsp_rdata", i), a_rsp_rdata, vecs[i].exp_rdata);
        end
        a_req_valid = 1'b0;
        tick();
        chk("valid one cycle", 32'(a_rsp_valid), 32'd0);
        chk("rdata hold", a_rsp_rdata, 32'd0);

        // Read, then clr_req with a competing write on the following cycle.
        a_req(1'b0, 4'h0, 7'd127, 32'h0);
        a_clr_req   = 1'b1;
        a_req_valid = 1'b1;
        a_req_we    = 1'b1;
        a_req_be    = 4'hF;
        a_req_addr  = 7'd5;
        a_req_wdata = 32'hFFFFFFFF;
        #1;
        chk("clr read rsp_valid", 32'(a_rsp_valid), 32'd1);
        chk("clr read rsp_rdata", a_rsp_rdata, 32'hDEADBEEF);
        chk("clr ready low", 32'(a_req_ready), 32'd0);
        tick();
        a_clr_req   = 1'b0;
        a_req_valid = 1'b0;
        chk("clr busy", 32'(a_busy), 32'd1);
        chk("clr rsp_valid drop", 32'(a_rsp_valid), 32'd0);
        a_wait_idle(n);
        chk("clr init cycles", 32'(n), 32'd130);
        a_req(1'b0, 4'h0, 7'd5, 32'h0);
        chk("clr read5", a_rsp_rdata, 32'h0);
        a_req(1'b0, 4'h0, 7'd10, 32'h0);
        chk("clr read10", a_rsp_rdata, 32'h0);
        a_req(1'b0, 4'h0, 7'd3, 32'h0);
        chk("clr read3", a_rsp_rdata, 32'h0800000F);

        // Overwrite boot words, then reset while a read response is showing.
        a_req(1'b1, 4'hF, 7'd3, 32'h12345678);
        a_req(1'b1, 4'hF, 7'd4, 32'h9999AAAA);
        a_req(1'b0, 4'h0, 7'd4, 32'h0);
        a_req_valid = 1'b0;
        chk("pre-reset rdata", a_rsp_rdata, 32'h9999AAAA);
        a_reset = 1'b1;
        #1;
        chk("async rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("async rsp_rdata", a_rsp_rdata, 32'd0);
        chk("async busy", 32'(a_busy), 32'd1);
        tick();
        a_reset = 1'b0;
        for (int i = 0; i < 129; i++) tick();
        chk("mid-boot busy", 32'(a_busy), 32'd1);
        a_reset = 1'b1;
        #1;
        chk("mid-boot ready", 32'(a_req_ready), 32'd0);
        chk("mid-boot rsp_valid", 32'(a_rsp_valid), 32'd0);
        #2;
        a_reset = 1'b0;
        a_wait_idle(n);
        chk("restart cycles", 32'(n), 32'd130);
        a_req(1'b0, 4'h0, 7'd3, 32'h0);
        chk("reboot read3", a_rsp_rdata, 32'h0800000F);
        a_req(1'b0, 4'h0, 7'd4, 32'h0);
        chk("reboot read4", a_rsp_rdata, 32'h20A50005);
        a_req(1'b0, 4'h0, 7'd5, 32'h0);
        chk("reboot read5", a_rsp_rdata, 32'h0);
        a_req_valid = 1'b0;

        // Instance B: 16-bit data memory.
        b_reset = 1'b0;
        n = 0;
        while (b_busy && n < 1000) begin
            tick();
            n++;
        end
        chk("b init cycles", 32'(n), 32'd16);
        b_req_valid = 1'b1;
        b_req_we    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_req_addr = 4'(i);
            tick();
            chk($sformatf("b read%0d", i), {15'd0, b_rsp_valid, b_rsp_rdata}, 32'h0001_0000);
        end
        b_req_we    = 1'b1;
        b_req_be    = 2'b10;
        b_req_addr  = 4'd15;
        b_req_wdata = 16'hAB12;
        tick();
        chk("b write rsp_valid", 32'(b_rsp_valid), 32'd0);
        b_req_we = 1'b0;
        tick();
        chk("b read15 be", {15'd0, b_rsp_valid, b_rsp_rdata}, 32'h0001_AB00);
        b_req_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/boot_ram.md
BOOT_RAM -- requirements
Module: boot_ram

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, word width in bits; a multiple of 8.
REQ-002 SHALL provide parameter ADDR_W, default 7, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL provide parameter MEM_KIND, default 0, where 0 = data memory (clear only) and 1 = instruction memory (clear, then boot image).
REQ-004 SHALL provide parameter BOOT_BASE, default 0, first word address of the boot image.
REQ-005 SHALL provide parameter BOOT_LEN, default 4, number of boot words, in the range 1..DEPTH-BOOT_BASE.
REQ-006 SHALL provide parameter BOOT_IMG, BOOT_LEN*DATA_W bits, default all zero; word i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL provide port clock, input, 1 bit, single clock; all state updates on the rising edge.
REQ-008 SHALL provide port reset, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL provide port clr_req, input, 1 bit, software request to re-run the init sequence.
REQ-010 SHALL provide port req_valid, input, 1 bit, access request.
REQ-011 SHALL provide port req_ready, output, 1 bit, block accepts a request this cycle.
REQ-012 SHALL provide port req_we, input, 1 bit, where 1 = write and 0 = read.
REQ-013 SHALL provide port req_be, input, DATA_W/8 bits, byte enables for writes.
REQ-014 SHALL provide port req_addr, input, ADDR_W bits, word address.
REQ-015 SHALL provide port req_wdata, input, DATA_W bits, write data.
REQ-016 SHALL provide port rsp_valid, output, 1 bit, read data valid.
REQ-017 SHALL provide port rsp_rdata, output, DATA_W bits, read data.
REQ-018 SHALL provide port busy, output, 1 bit, init sequence in progress.

Function
REQ-019 SHALL implement the FSM states CLEAR, BOOT, and IDLE.
REQ-020 SHALL, in CLEAR, write zero to one address per cycle, ascending from 0; after address DEPTH-1 it goes to BOOT if MEM_KIND=1, else to IDLE.
REQ-021 SHALL, in BOOT, write BOOT_IMG word i to BOOT_BASE+i, one word per cycle, for i = 0..BOOT_LEN-1, then go to IDLE.
REQ-022 SHALL take exactly DEPTH cycles for init when MEM_KIND=0, or DEPTH+BOOT_LEN cycles when MEM_KIND=1.
REQ-023 SHALL drive busy=1 in CLEAR and BOOT and busy=0 in IDLE.
REQ-024 SHALL drive req_ready = (state==IDLE) && !clr_req, combinationally.
REQ-025 SHALL accept a request only on a cycle where req_valid && req_ready; requests presented while req_ready=0 are ignored, not queued.
REQ-026 SHALL, on an accepted write, update each byte k of mem[req_addr] to req_wdata byte k only where req_be[k]=1; other bytes hold.
REQ-027 SHALL, on an accepted write, hold rsp_valid=0 on the next cycle.
REQ-028 SHALL, on an accepted read, set rsp_valid=1 and rsp_rdata=mem[req_addr] on the next cycle (latency 1).
REQ-029 SHALL keep rsp_valid high for exactly one cycle per accepted read.
REQ-030 SHALL hold rsp_rdata at its last value otherwise.
REQ-031 SHALL support back-to-back accepted requests every cycle with full throughput.
REQ-032 SHALL, on a read issued the cycle after a write to the same address, return the new data.
REQ-033 SHALL, on clr_req=1 in IDLE, go to CLEAR on the next cycle with the address counter at 0.
REQ-034 SHALL ignore clr_req in CLEAR and BOOT, with no restart.
REQ-035 SHALL, on clr_req and req_valid in the same IDLE cycle, give clr_req priority; the request is not accepted.
REQ-036 SHALL, when clr_req is accepted one cycle after a read was accepted, still deliver that read's response.
REQ-037 SHALL have the init counter wrap only at DEPTH-1 to the state transition; it never wraps to 0 within CLEAR.

Reset
REQ-038 SHALL, on reset asserted, immediately force state CLEAR, the counter to 0, rsp_valid=0, rsp_rdata=0, busy=1, and req_ready=0.
REQ-039 SHALL, on reset asserted mid-CLEAR or mid-BOOT, restart the init from address 0 after deassertion.
REQ-040 SHALL not depend on memory contents being reset; they are defined only by completion of the init.

Verification
REQ-041 SHALL verify init with MEM_KIND=1, BOOT_BASE=3, BOOT_LEN=2, BOOT_IMG={32'h20A50005, 32'h0800000F}: release reset -> busy falls after 130 cycles; read 3 -> 32'h0800000F; read 4 -> 32'h20A50005; read 5 -> 0.
REQ-042 SHALL verify byte-enable writes: write addr 10 data 32'hAABBCCDD be=4'b1111, then write 32'h11223344 be=4'b0101 -> read 10 returns 32'hAA22CC44.
REQ-043 SHALL verify back-to-back access: write addr 127 = 32'hDEADBEEF, next cycle read 127 -> rsp_valid one cycle later with 32'hDEADBEEF; read addr 0 on the following cycle -> 0.
REQ-044 SHALL verify clr_req priority: clr_req=1 with req_valid=1 write addr 5 in IDLE -> write not accepted, busy=1 for 130 cycles, then read 5 -> 0.
REQ-045 SHALL verify reset mid-BOOT: assert reset at init cycle 129 -> rsp_valid=0 and req_ready=0 immediately; after deassertion busy holds 130 cycles; boot words are correct.
REQ-046 SHALL verify MEM_KIND=0 with DATA_W=16, ADDR_W=4: init takes 16 cycles; all addresses read 0; a write to addr 15 with be=2'b10 and data 16'hAB12 -> read returns 16'hAB00.
